// File: rtl/sdram_line_fill.sv
// SDRAM-domain line-fill engine: packs 16-bit burst beats into 32-bit words and writes them to the
// line buffer, tracking a per-word valid bitmap. Optional macro: LINE_FILL_CRITICAL_WORD_FIRST_EN.
module sdram_line_fill #(
  parameter int ADDR_WIDTH = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         fill_start_i,
  input  logic [ADDR_WIDTH-1:0]        fill_addr_i,
  input  logic                         fill_abort_i,
  input  logic                         sdram_dv_i,
  input  logic [15:0]                  sdram_dat_i,
  output logic                         fill_busy_o,
  output logic                         fill_done_o,
  output logic [(2**ADDR_WIDTH)-1:0]   word_valid_o,
  output logic [ADDR_WIDTH-1:0]        buf_addr_o,
  output logic [3:0]                   buf_we_o,
  output logic [31:0]                  buf_di_o
);

  localparam int LINE_WORDS = 2**ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [15:0]             hold_q, hold_d;
  logic [3:0]              we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             di_q, di_d;
  logic                    last_q, last_d;
  logic [LINE_WORDS-1:0]   valid_q, valid_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic [ADDR_WIDTH-1:0]   ptr_load;
  logic [LINE_WORDS-1:0]   commit_mask;

`ifdef LINE_FILL_CRITICAL_WORD_FIRST_EN
  assign ptr_load = fill_addr_i;
`else
  // Fills always run from word 0; the address input is deliberately masked off.
  assign ptr_load = fill_addr_i & {ADDR_WIDTH{1'b0}};
`endif

  assign commit_mask = {{(LINE_WORDS-1){1'b0}}, 1'b1} << addr_q;

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      hold_q  <= 16'h0000;
      we_q    <= 4'h0;
      addr_q  <= '0;
      di_q    <= 32'h0000_0000;
      last_q  <= 1'b0;
      valid_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      di_q    <= di_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state, beat packing, commit tracking and abort handling.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    we_d    = 4'h0;
    addr_d  = addr_q;
    di_d    = di_q;
    last_d  = 1'b0;
    valid_d = valid_q;
    done_d  = 1'b0;
    busy_d  = busy_q;

    // A write on the bus this cycle lands in the RAM at this edge, so its valid bit follows.
    if (we_q != 4'h0) begin
      valid_d = valid_q | commit_mask;
      if (last_q) begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end else begin
        done_d = 1'b0;
      end
    end else begin
      valid_d = valid_q;
    end

    case (state_q)
      ST_IDLE: begin
        // busy_q stays high for the final commit cycle, which holds off a new start until then.
        if (fill_start_i && !busy_q) begin
          valid_d = '0;
          ptr_d   = ptr_load;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_HI;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HI: begin
        if (sdram_dv_i) begin
          hold_d  = sdram_dat_i;
          state_d = ST_LO;
        end else begin
          state_d = ST_HI;
        end
      end
      ST_LO: begin
        if (sdram_dv_i) begin
          we_d    = 4'hF;
          addr_d  = ptr_q;
          di_d    = {hold_q, sdram_dat_i};
          ptr_d   = ptr_q + ADDR_WIDTH'(1);
          cnt_d   = cnt_q + ADDR_WIDTH'(1);
          last_d  = (cnt_q == {ADDR_WIDTH{1'b1}});
          state_d = (cnt_q == {ADDR_WIDTH{1'b1}}) ? ST_IDLE : ST_HI;
        end else begin
          state_d = ST_LO;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort wins over any beat this cycle; a write already on the bus still commits above.
    if (fill_abort_i && busy_q) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      we_d    = 4'h0;
      last_d  = 1'b0;
      addr_d  = addr_q;
      di_d    = di_q;
    end else begin
      state_d = state_d;
    end
  end

  assign fill_busy_o  = busy_q;
  assign fill_done_o  = done_q;
  assign word_valid_o = valid_q;
  assign buf_addr_o   = addr_q;
  assign buf_we_o     = we_q;
  assign buf_di_o     = di_q;

endmodule

// File: tb/tb_sdram_line_fill.sv
// Scoreboard bench for sdram_line_fill: expected writes and fill_done cycles are queued by the stimulus
// and checked by a negedge monitor. Expectations follow LINE_FILL_CRITICAL_WORD_FIRST_EN when defined.
module tb_sdram_line_fill;

  logic        clk;
  logic        rst_n;
  logic        fill_start;
  logic [2:0]  fill_addr;
  logic        fill_abort;
  logic        sdram_dv;
  logic [15:0] sdram_dat;
  logic        fill_busy;
  logic        fill_done;
  logic [7:0]  word_valid;
  logic [2:0]  buf_addr;
  logic [3:0]  buf_we;
  logic [31:0] buf_di;

  sdram_line_fill #(.ADDR_WIDTH(3)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .fill_start_i (fill_start),
    .fill_addr_i  (fill_addr),
    .fill_abort_i (fill_abort),
    .sdram_dv_i   (sdram_dv),
    .sdram_dat_i  (sdram_dat),
    .fill_busy_o  (fill_busy),
    .fill_done_o  (fill_done),
    .word_valid_o (word_valid),
    .buf_addr_o   (buf_addr),
    .buf_we_o     (buf_we),
    .buf_di_o     (buf_di)
  );

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t        wq[$];
  int         dq[$];
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  logic [2:0] mptr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] first_addr(input logic [2:0] a);
`ifdef LINE_FILL_CRITICAL_WORD_FIRST_EN
    return a;
`else
    return 3'd0 & a;
`endif
  endfunction

  // Monitor: every write and every fill_done pulse must match the head of its queue.
  always @(negedge clk) begin
    if (buf_we !== 4'h0) begin
      if (wq.size() == 0) begin
        chk("unexpected_write", {29'd0, buf_addr}, 64'hFFFF);
      end else begin
        wr_t w;
        w = wq.pop_front();
        chk("wr_we", buf_we, 4'hF);
        chk("wr_addr", buf_addr, w.addr);
        chk("wr_data", buf_di, w.data);
        chk("wr_cycle", cyc, w.cyc);
      end
    end
    if (fill_done === 1'b1) begin
      if (dq.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        int d;
        d = dq.pop_front();
        chk("done_cycle", cyc, d);
      end
    end
  end

  // Start a fill; a beat offered in the start cycle must be ignored.
  task automatic start_fill(input logic [2:0] a);
    fill_start = 1'b1;
    fill_addr  = a;
    sdram_dv   = 1'b1;
    sdram_dat  = 16'hDEAD;
    tick();
    fill_start = 1'b0;
    sdram_dv   = 1'b0;
    mptr       = first_addr(a);
    chk("busy_after_start", fill_busy, 1'b1);
    chk("valid_cleared", word_valid, 8'h00);
  endtask

  // Pair k carries beats 2k+1 (upper) and 2k+2 (lower) plus a per-test offset.
  task automatic send_pairs(input int k0, input int n, input bit gap, input logic [15:0] base);
    for (int k = k0; k < k0 + n; k++) begin
      logic [15:0] hi;
      logic [15:0] lo;
      hi = base + 16'(2 * k + 1);
      lo = base + 16'(2 * k + 2);
      sdram_dv  = 1'b1;
      sdram_dat = hi;
      tick();
      if (gap) begin
        sdram_dv = 1'b0;
        tick();
      end
      sdram_dv  = 1'b1;
      sdram_dat = lo;
      wq.push_back('{mptr, {hi, lo}, cyc + 1});
      if (k == 7) dq.push_back(cyc + 2);
      mptr = mptr + 3'd1;
      tick();
      sdram_dv = 1'b0;
      if (gap) tick();
    end
  endtask

  // Called in the cycle after the final lower beat (gap=0) or two cycles after (gap=1).
  task automatic finish_fill(input bit gap);
    logic [7:0] part;
    part = 8'hFF ^ (8'h01 << (mptr - 3'd1));
    if (!gap) begin
      chk("busy_before_done", fill_busy, 1'b1);
      chk("valid_before_done", word_valid, part);
      tick();
    end
    chk("valid_full", word_valid, 8'hFF);
    chk("busy_after_done", fill_busy, 1'b0);
    tick();
    chk("write_queue_empty", wq.size(), 0);
    chk("done_queue_empty", dq.size(), 0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy", fill_busy, 1'b0);
    chk("rst_done", fill_done, 1'b0);
    chk("rst_valid", word_valid, 8'h00);
    chk("rst_we", buf_we, 4'h0);
    chk("rst_addr", buf_addr, 3'd0);
    chk("rst_di", buf_di, 32'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; fill_start = 1'b0; fill_addr = 3'd0; fill_abort = 1'b0;
    sdram_dv = 1'b0; sdram_dat = 16'h0000; mptr = 3'd0;
    tick(); tick();
    chk_reset_outputs();
    rst_n = 1'b1;
    tick();

    // Straight fill, back-to-back beats 0x0001..0x0010.
    start_fill(3'd3);
    send_pairs(0, 8, 1'b0, 16'h0000);
    finish_fill(1'b0);

    // Critical word first from 5, with a fill_start attempt mid-fill.
    start_fill(3'd5);
    send_pairs(0, 3, 1'b0, 16'h1000);
    fill_start = 1'b1; fill_addr = 3'd2;
    tick();
    fill_start = 1'b0;
`ifdef LINE_FILL_CRITICAL_WORD_FIRST_EN
    chk("valid_after_3", word_valid, 8'hE0);
`else
    chk("valid_after_3", word_valid, 8'h07);
`endif
    chk("busy_ignored_start", fill_busy, 1'b1);
    send_pairs(3, 5, 1'b0, 16'h1000);
    finish_fill(1'b0);

    // Gappy stream: valid toggles 1,0 on every beat.
    start_fill(3'd0);
    send_pairs(0, 8, 1'b1, 16'h0000);
    finish_fill(1'b1);

    // Abort after three words plus a held upper half; a lower beat in the abort cycle is dropped.
    start_fill(3'd0);
    send_pairs(0, 3, 1'b0, 16'h2000);
    sdram_dv = 1'b1; sdram_dat = 16'hAAAA;
    tick();
    sdram_dv = 1'b1; sdram_dat = 16'hBBBB; fill_abort = 1'b1;
    chk("valid_at_abort", word_valid, 8'h07);
    tick();
    fill_abort = 1'b0; sdram_dv = 1'b0;
    chk("busy_after_abort", fill_busy, 1'b0);
    chk("valid_after_abort", word_valid, 8'h07);
    chk("no_done_abort", fill_done, 1'b0);
    chk("no_write_abort", buf_we, 4'h0);
    tick();
    start_fill(3'd0);
    fill_abort = 1'b1;
    tick();
    fill_abort = 1'b0;
    chk("busy_after_abort2", fill_busy, 1'b0);
    chk("abort_queue_empty", wq.size(), 0);

    // Reset mid-fill while a lower beat is offered; later beats are ignored without fill_start.
    start_fill(3'd0);
    send_pairs(0, 4, 1'b0, 16'h3000);
    sdram_dv = 1'b1; sdram_dat = 16'hAAAA;
    tick();
    rst_n = 1'b0; sdram_dat = 16'hBBBB;
    tick();
    rst_n = 1'b1; sdram_dv = 1'b0;
    chk_reset_outputs();
    for (int i = 0; i < 6; i++) begin
      sdram_dv = 1'b1; sdram_dat = 16'(16'h5000 + i);
      tick();
    end
    sdram_dv = 1'b0;
    tick();
    chk("valid_after_rst", word_valid, 8'h00);
    chk("busy_after_rst", fill_busy, 1'b0);
    chk("rst_queue_empty", wq.size(), 0);
    chk("rst_done_queue_empty", dq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
